ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one single-port 1024x10 RAM (sync write,
//  registered read address, combinational rdata) between two requesters.
//  Latches the winning request, drives the RAM for one cycle, captures read data,
//  returns a one-cycle ack. Sits between client logic and the RAM instance.
// PARAMETERS
//  ADDR_W  10  RAM address width (depth = 2**ADDR_W)
//  DATA_W  10  RAM data width
// PORTS
//  clk        in   1       clock, all logic on posedge
//  rst        in   1       synchronous reset, active-high
//  req0/req1  in   1       request from port 0/1; hold high until ack
//  we0/we1    in   1       1 = write, 0 = read; valid while req high
//  addr0/1    in   ADDR_W  request address
//  wdata0/1   in   DATA_W  write data
//  ack0/ack1  out  1       one-cycle completion pulse, registered
//  rdata0/1   out  DATA_W  read data; valid while ackN high after a read
//  busy       out  1       high whenever state != IDLE
//  ram_we     out  1       to RAM we
//  ram_addr   out  ADDR_W  to RAM address
//  ram_wdata  out  DATA_W  to RAM wdata
//  ram_rdata  in   DATA_W  from RAM rdata
// BEHAVIOUR
//  Reset (sync, active-high): state=IDLE, ack0/1=0, rdata0/1=0, busy=0, ram_we=0,
//   ram_addr=0, ram_wdata=0, last_grant=1 (port 0 wins first tie).
//  FSM: IDLE -> ISSUE -> (read only) CAPTURE -> ACK -> IDLE.
//  IDLE: if any req, pick winner, latch we/addr/wdata of winner, set last_grant,
//   go ISSUE. No req: stay IDLE.
//  Arbitration: only one req -> that port. Both -> port != last_grant.
//  ISSUE (1 cycle): ram_addr/ram_wdata = latched values; ram_we = latched we.
//   RAM writes or latches read address at end of ISSUE. Write -> ACK; read -> CAPTURE.
//  CAPTURE (1 cycle): ram_rdata valid; register it into rdata of winning port.
//  ACK (1 cycle): ack of winning port = 1, other ack = 0; next state IDLE.
//  ram_we = 1 only in ISSUE with latched we=1; 0 in all other states.
//  ram_addr/ram_wdata hold last latched values outside ISSUE.
//  Latency (req high in IDLE cycle C0): write ack in C2; read ack + rdata in C3.
//  Requester inputs changing after grant are ignored until ack.
//  Requester drops req (or presents a new op) on the edge ending its ack cycle;
//   req high in the cycle after ack is a new request.
//  Losing port stays pending, gets the next grant (no starvation; max wait = 1 op).
//  rdataN holds its value until the next read for that port completes; writes
//   do not alter rdataN.
//  Reset mid-op: FSM -> IDLE at that edge, no ack issued. A write whose ISSUE
//   cycle coincides with the reset edge is committed to RAM; reads are discarded.
//  Address wrap: none; 0 and 2**ADDR_W-1 handled identically to others.
// TESTING
//  1. Port0 write addr=0 data=0x001, then read addr=0 -> ack0 at C2 (write),
//     ack0 at C3 with rdata0=0x001; ack1 never asserted.
//  2. req0 & req1 same cycle after reset (writes 0x011@5, 0x022@6) -> port0
//     granted first, port1 next; readback gives 0x011@5, 0x022@6.
//  3. Both held requesting reads back-to-back -> grants alternate 0,1,0,1;
//     each port acked once per two ops; ram_we stays 0 throughout.
//  4. Port1 write 0x3FF@1023 then read 1023 -> rdata1=0x3FF with ack1; rdata0
//     unchanged.
//  5. Assert rst during CAPTURE of a port0 read -> no ack0, busy=0 next cycle,
//     rdata0 unchanged; next request serviced normally.
//  6. Change addr0/wdata0 during ISSUE -> RAM sees originally latched values only.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// Bundle of client request/ack signals and RAM-side signals for ram_arbiter.
// Handshake: a client raises reqN with weN/addrN/wdataN stable and keeps it high until ackN pulses for one cycle; it drops or replaces the request on the edge that ends the ack cycle.
interface ram_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 10
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              busy;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        output ack0, ack1, rdata0, rdata1, busy, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_rdata,
        input  ack0, ack1, rdata0, rdata1, busy, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin sequencer sharing one single-port RAM (sync write, registered read
// address, combinational rdata) between two requesters; one op in flight at a time.
module ram_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 10
) (
    input  logic         clk,
    input  logic         rst,
    ram_arbiter_if.slave bus,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;
    logic              any_req;
    logic              pick;
    logic              grant;
    logic              capture;
    logic              ack_set;
    logic              cur;
    logic              last_grant;
    logic              ack0_q;
    logic              ack1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;

    assign any_req = bus.req0 | bus.req1;
    // On a tie the port that did not win last time goes next.
    assign pick    = (bus.req0 & bus.req1) ? ~last_grant : bus.req1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        capture = 1'b0;
        ack_set = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    grant   = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                // ram_we_q holds the latched op type for exactly this cycle.
                ack_set = ram_we_q;
                state_n = ram_we_q ? ACK : CAPTURE;
            end
            CAPTURE: begin
                capture = 1'b1;
                ack_set = 1'b1;
                state_n = ACK;
            end
            ACK: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= 1'b0;
            last_grant  <= 1'b1;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            ack0_q   <= ack_set & ~cur;
            ack1_q   <= ack_set & cur;
            ram_we_q <= 1'b0;
            if (grant) begin
                cur         <= pick;
                last_grant  <= pick;
                ram_we_q    <= pick ? bus.we1 : bus.we0;
                ram_addr_q  <= pick ? bus.addr1 : bus.addr0;
                ram_wdata_q <= pick ? bus.wdata1 : bus.wdata0;
            end
            if (capture) begin
                if (cur) begin
                    rdata1_q <= bus.ram_rdata;
                end else begin
                    rdata0_q <= bus.ram_rdata;
                end
            end
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.busy      = (state != IDLE);
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, transaction-level reference model with
// an expected-ack queue, and a monitor that checks every ack against it.
module tb_ram_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 10;
    localparam int W      = 28;  // {ack_cycle[15:0], port, is_read, rdata[9:0]}

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        dbg_state;
    logic              req_v   [2];
    logic              we_v    [2];
    logic [ADDR_W-1:0] addr_v  [2];
    logic [DATA_W-1:0] wdata_v [2];

    ram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    assign bus.req0   = req_v[0];
    assign bus.req1   = req_v[1];
    assign bus.we0    = we_v[0];
    assign bus.we1    = we_v[1];
    assign bus.addr0  = addr_v[0];
    assign bus.addr1  = addr_v[1];
    assign bus.wdata0 = wdata_v[0];
    assign bus.wdata1 = wdata_v[1];

    // clock / reset
    always #5 clk = ~clk;

    // RAM instance: sync write, registered read address, combinational rdata
    logic [DATA_W-1:0] ram_mem [1024];
    logic [ADDR_W-1:0] ram_raddr;
    always @(posedge clk) begin
        if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
        ram_raddr <= bus.ram_addr;
    end
    assign bus.ram_rdata = ram_mem[ram_raddr];

    // scoreboard state
    int                errors = 0;
    int                checks = 0;
    logic [W-1:0]      exp_q[$];
    int                cyc = 0;
    logic [DATA_W-1:0] mem_ref [1024];
    logic [DATA_W-1:0] rdata_ref [2];
    int                last_g = 1;
    int                free_at = 0;
    logic              pend = 1'b0;
    int                pend_issue = 0;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_wdata;
    int                model_writes = 0;
    int                we_cycles = 0;
    int                m_w;
    int                m_lat;
    int                mon_p;
    logic [W-1:0]      mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one op at a time; write acks 2 cycles after grant, read acks 3.
    always @(posedge clk) begin
        if (pend && cyc == pend_issue) begin
            mem_ref[pend_addr] = pend_wdata;
            model_writes++;
            pend = 1'b0;
        end
        if (rst) begin
            pend         = 1'b0;
            exp_q.delete();
            last_g       = 1;
            rdata_ref[0] = '0;
            rdata_ref[1] = '0;
            free_at      = cyc + 1;
        end else if (cyc >= free_at && (req_v[0] || req_v[1])) begin
            if (req_v[0] && req_v[1]) m_w = 1 - last_g;
            else                      m_w = req_v[1] ? 1 : 0;
            last_g = m_w;
            if (we_v[m_w]) begin
                m_lat      = 2;
                pend       = 1'b1;
                pend_issue = cyc + 1;
                pend_addr  = addr_v[m_w];
                pend_wdata = wdata_v[m_w];
            end else begin
                m_lat = 3;
            end
            exp_q.push_back({16'(cyc + m_lat), 1'(m_w), ~we_v[m_w],
                             (we_v[m_w] ? 10'd0 : mem_ref[addr_v[m_w]])});
            free_at = cyc + m_lat + 1;
        end
        cyc++;
    end

    // Monitor: every ack must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.ram_we) we_cycles++;
        if (bus.ack0 || bus.ack1) begin
            mon_p = bus.ack1 ? 1 : 0;
            check("ack_onehot", {31'd0, bus.ack0 & bus.ack1}, 32'd0);
            check("busy_in_ack", {31'd0, bus.busy}, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ack on port %0d, expected no ack (cycle %0d)", mon_p, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_port", mon_p, {31'd0, mon_e[11]});
                check("ack_cycle", cyc, {16'd0, mon_e[27:12]});
                if (mon_e[10]) rdata_ref[mon_e[11]] = mon_e[9:0];
                check("rdata0", {22'd0, bus.rdata0}, {22'd0, rdata_ref[0]});
                check("rdata1", {22'd0, bus.rdata1}, {22'd0, rdata_ref[1]});
            end
        end
    end

    // driver tasks (called #1 after a posedge)
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic do_op(input int p, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input bit scramble);
        int  n;
        logic got;
        req_v[p]   = 1'b1;
        we_v[p]    = w;
        addr_v[p]  = a;
        wdata_v[p] = d;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (scramble && n == 1) begin
                addr_v[p]  = ~a;
                wdata_v[p] = ~d;
            end
            got = (p == 1) ? bus.ack1 : bus.ack0;
        end while (!got && n < 60);
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: port %0d got no ack, expected one within 60 cycles", p);
        end
        @(posedge clk);
        #1;
        req_v[p] = 1'b0;
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return 10'($urandom_range(0, 7));
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int snap;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_v[i]   = 1'b0;
            we_v[i]    = 1'b0;
            addr_v[i]  = '0;
            wdata_v[i] = '0;
            rdata_ref[i] = '0;
        end
        for (int i = 0; i < 1024; i++) begin
            ram_mem[i] = '0;
            mem_ref[i] = '0;
        end
        do_reset();

        check("rst_ack0", {31'd0, bus.ack0}, 32'd0);
        check("rst_ack1", {31'd0, bus.ack1}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_ram_we", {31'd0, bus.ram_we}, 32'd0);
        check("rst_ram_addr", {22'd0, bus.ram_addr}, 32'd0);
        check("rst_ram_wdata", {22'd0, bus.ram_wdata}, 32'd0);
        check("rst_rdata0", {22'd0, bus.rdata0}, 32'd0);
        check("rst_rdata1", {22'd0, bus.rdata1}, 32'd0);

        // single-port write then read at address 0
        do_op(0, 1'b1, 10'd0, 10'h001, 1'b0);
        do_op(0, 1'b0, 10'd0, 10'h000, 1'b0);
        check("t1_rdata0", {22'd0, bus.rdata0}, 32'h001);

        // simultaneous requests right after reset: port 0 first
        do_reset();
        fork
            do_op(0, 1'b1, 10'd5, 10'h011, 1'b0);
            do_op(1, 1'b1, 10'd6, 10'h022, 1'b0);
        join
        fork
            do_op(0, 1'b0, 10'd5, 10'h000, 1'b0);
            do_op(1, 1'b0, 10'd6, 10'h000, 1'b0);
        join
        check("t2_rdata0", {22'd0, bus.rdata0}, 32'h011);
        check("t2_rdata1", {22'd0, bus.rdata1}, 32'h022);

        // both ports streaming reads back to back
        snap = we_cycles;
        fork
            begin
                do_op(0, 1'b0, 10'd5, 10'h000, 1'b0);
                do_op(0, 1'b0, 10'd6, 10'h000, 1'b0);
                do_op(0, 1'b0, 10'd0, 10'h000, 1'b0);
                do_op(0, 1'b0, 10'd1023, 10'h000, 1'b0);
            end
            begin
                do_op(1, 1'b0, 10'd6, 10'h000, 1'b0);
                do_op(1, 1'b0, 10'd0, 10'h000, 1'b0);
                do_op(1, 1'b0, 10'd5, 10'h000, 1'b0);
                do_op(1, 1'b0, 10'd7, 10'h000, 1'b0);
            end
        join
        check("t3_no_ram_we", we_cycles - snap, 32'd0);

        // top address through port 1
        do_op(1, 1'b1, 10'd1023, 10'h3FF, 1'b0);
        do_op(1, 1'b0, 10'd1023, 10'h000, 1'b0);
        check("t4_rdata1", {22'd0, bus.rdata1}, 32'h3FF);

        // reset while a port 0 read sits in CAPTURE
        do_reset();
        req_v[0]  = 1'b1;
        we_v[0]   = 1'b0;
        addr_v[0] = 10'd5;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst      = 1'b1;
        req_v[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_busy_after_rst", {31'd0, bus.busy}, 32'd0);
        check("t5_no_ack0", {31'd0, bus.ack0}, 32'd0);
        check("t5_rdata0", {22'd0, bus.rdata0}, 32'd0);
        do_op(0, 1'b0, 10'd5, 10'h000, 1'b0);
        check("t5_rdata0_after", {22'd0, bus.rdata0}, 32'h011);

        // request fields change during ISSUE: RAM must see the latched ones
        do_op(0, 1'b1, 10'd100, 10'h155, 1'b1);
        do_op(0, 1'b0, 10'd100, 10'h000, 1'b0);
        check("t6_rdata0", {22'd0, bus.rdata0}, 32'h155);
        do_op(0, 1'b0, ~10'd100, 10'h000, 1'b0);
        check("t6_other_addr", {22'd0, bus.rdata0}, 32'h000);

        // randomized traffic from both ports
        fork
            for (int i = 0; i < 25; i++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                do_op(0, 1'($urandom_range(0, 1)), rand_addr(), 10'($urandom_range(0, 1023)), 1'b0);
            end
            for (int j = 0; j < 25; j++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                do_op(1, 1'($urandom_range(0, 1)), rand_addr(), 10'($urandom_range(0, 1023)), 1'b0);
            end
        join

        repeat (5) @(posedge clk);
        #1;
        check("ram_we_cycles", we_cycles, model_writes);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
